// File: rtl/timer_pkg.sv
// Shared types and default sizing for the timer controller and the tick generator.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        FLAG  = 2'd2
    } state_t;

    localparam int DIV_W_DEF       = 24;
    localparam int TC_W_DEF        = 16;
    localparam int DEFAULT_DIV_DEF = 250;
    localparam int ACK_TIMEOUT_DEF = 15;

endpackage

// File: rtl/timer_tick_gen_if.sv
// Handshake between the timer controller (master) and the tick generator (slave).
interface timer_tick_gen_if;

    logic rst_in;
    logic ena_in;
    logic flag_out;
    logic busy;

    modport master (
        output rst_in,
        output ena_in,
        input  flag_out,
        input  busy
    );

    modport slave (
        input  rst_in,
        input  ena_in,
        output flag_out,
        output busy
    );

endinterface

// File: rtl/timer_ack_watchdog.sv
// Counts unacknowledged FLAG cycles and latches a sticky overrun at ACK_TIMEOUT.
module timer_ack_watchdog #(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic overrun
);

    localparam int WD_W = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(ACK_TIMEOUT);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            ovr_q, ovr_d;

    always_comb begin
        wd_d  = wd_q;
        ovr_d = ovr_q;
        if (clr) begin
            wd_d = '0;
        end else if (inc) begin
            if (wd_q != WD_MAX) begin
                wd_d = wd_q + WD_W'(1);
            end
            // Overrun latches on the same edge the count reaches the limit.
            if (wd_d == WD_MAX) begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wd_q  <= '0;
            ovr_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            ovr_q <= ovr_d;
        end
    end

    assign overrun = ovr_q;

endmodule

// File: rtl/timer_tick_gen.sv
// Programmable prescaler that raises a held tick flag each divisor period and
// waits for the controller to acknowledge it by pulling rst_in low.
module timer_tick_gen
    import timer_pkg::*;
#(
    parameter int DIV_W       = DIV_W_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF,
    parameter int TC_W        = TC_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    timer_tick_gen_if.slave   ctl,
    input  logic              div_load,
    input  logic [DIV_W-1:0]  div_value,
    output logic              overrun,
    output logic [TC_W-1:0]   tick_count,
    output logic [DIV_W-1:0]  div_active
);

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_shadow_q, div_shadow_d;
    logic [DIV_W-1:0] div_active_q, div_active_d;
    logic [DIV_W-1:0] div_load_val;
    logic             flag_q, flag_d;
    logic [TC_W-1:0]  tick_q, tick_d;
    logic             wd_inc, wd_clr;

    always_comb begin
        // A zero divisor would never reach terminal count, so it is stored as 1.
        div_load_val = (div_value == '0) ? DIV_W'(1) : div_value;
        div_shadow_d = div_load ? div_load_val : div_shadow_q;

        state_d      = state_q;
        cnt_d        = cnt_q;
        div_active_d = div_active_q;
        flag_d       = 1'b0;
        tick_d       = tick_q;
        wd_inc       = 1'b0;
        wd_clr       = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                wd_clr = 1'b1;
                if (ctl.rst_in && ctl.ena_in) begin
                    state_d      = COUNT;
                    div_active_d = div_shadow_d;
                end
            end
            COUNT: begin
                if (!ctl.rst_in) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (ctl.ena_in) begin
                    if (cnt_q == div_active_q - DIV_W'(1)) begin
                        state_d = FLAG;
                        cnt_d   = '0;
                        flag_d  = 1'b1;
                        tick_d  = tick_q + TC_W'(1);
                    end else begin
                        cnt_d = cnt_q + DIV_W'(1);
                    end
                end
            end
            FLAG: begin
                cnt_d = '0;
                if (!ctl.rst_in) begin
                    state_d = IDLE;
                    wd_clr  = 1'b1;
                end else begin
                    flag_d = 1'b1;
                    wd_inc = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            div_shadow_q <= DIV_W'(DEFAULT_DIV);
            div_active_q <= DIV_W'(DEFAULT_DIV);
            flag_q       <= 1'b0;
            tick_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            div_shadow_q <= div_shadow_d;
            div_active_q <= div_active_d;
            flag_q       <= flag_d;
            tick_q       <= tick_d;
        end
    end

    timer_ack_watchdog #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_ack_watchdog (
        .clock   (clock),
        .reset   (reset),
        .clr     (wd_clr),
        .inc     (wd_inc),
        .overrun (overrun)
    );

    assign ctl.flag_out = flag_q;
    assign ctl.busy     = (state_q != IDLE);
    assign tick_count   = tick_q;
    assign div_active   = div_active_q;

endmodule

// File: tb/tb_timer_tick_gen.sv
// Scoreboard bench: the driver acts as the timer controller and predicts each
// tick's cycle, count and divisor; a monitor checks them when flag_out rises.
module tb_timer_tick_gen;

    localparam int DIV_W   = 24;
    localparam int TC_W    = 8;   // narrow tick counter so the wrap is reachable quickly
    localparam int DEF_DIV = 250;
    localparam int ACK_TO  = 15;

    logic             clock = 1'b0;
    logic             reset;
    logic             div_load;
    logic [DIV_W-1:0] div_value;
    logic             overrun;
    logic [TC_W-1:0]  tick_count;
    logic [DIV_W-1:0] div_active;

    timer_tick_gen_if tif ();

    timer_tick_gen #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEF_DIV),
        .ACK_TIMEOUT (ACK_TO),
        .TC_W        (TC_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .ctl        (tif.slave),
        .div_load   (div_load),
        .div_value  (div_value),
        .overrun    (overrun),
        .tick_count (tick_count),
        .div_active (div_active)
    );

    always #5 clock = ~clock;

    typedef struct {
        longint cyc;
        longint tick;
        longint div;
    } exp_t;

    exp_t   sb[$];
    longint cyc = 0;
    int     n_vec = 0;
    int     n_err = 0;

    longint shadow_m, active_m, tick_m;
    bit     ov_m;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset();
        shadow_m = DEF_DIV;
        active_m = DEF_DIV;
        tick_m   = 0;
        ov_m     = 1'b0;
        sb.delete();
    endtask

    function automatic longint sanitize(input longint v);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic check_idle(input string nm);
        chk({nm, "_flag"},       longint'(tif.flag_out), 0);
        chk({nm, "_busy"},       longint'(tif.busy), 0);
        chk({nm, "_overrun"},    longint'(overrun), longint'(ov_m));
        chk({nm, "_tick"},       longint'(tick_count), tick_m);
        chk({nm, "_div_active"}, longint'(div_active), active_m);
    endtask

    task automatic monitor();
        bit   prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clock);
            if (tif.flag_out && !prev) begin
                if (sb.size() == 0) begin
                    chk("flag_unexpected", longint'(tif.flag_out), 0);
                end else begin
                    e = sb.pop_front();
                    chk("flag_cycle", cyc, e.cyc);
                    chk("flag_tick_count", longint'(tick_count), e.tick);
                    chk("flag_div_active", longint'(div_active), e.div);
                end
            end
            prev = tif.flag_out;
        end
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            tif.rst_in = 1'($urandom_range(0, 1));
            tif.ena_in = tif.rst_in ? 1'b0 : 1'($urandom_range(0, 1));
            step();
            chk("idle_busy", longint'(tif.busy), 0);
        end
        tif.rst_in = 1'b0;
        tif.ena_in = 1'b0;
    endtask

    // One controller period: start, count (with optional pause/load/abort),
    // then hold the flag for `hold` cycles and acknowledge (or reset instead).
    task automatic run_period(input bit ld_start, input longint ld_start_val,
                              input int ld_mid_at, input longint ld_mid_val,
                              input int pause_at, input int pause_len,
                              input bit abort, input int hold, input bit rst_in_flag);
        longint k, exp_c;
        int     en_cnt, it, pcnt;
        tif.rst_in = 1'b1;
        tif.ena_in = 1'b1;
        if (ld_start) begin
            div_load  = 1'b1;
            div_value = DIV_W'(ld_start_val);
            shadow_m  = sanitize(ld_start_val);
        end
        active_m = shadow_m;
        k = cyc;
        if (!abort) begin
            tick_m = (tick_m + 1) % (longint'(1) << TC_W);
            exp_c  = k + 1 + active_m + ((pause_at < active_m) ? pause_len : 0);
            sb.push_back('{exp_c, tick_m, active_m});
        end
        step();
        div_load = 1'b0;
        en_cnt = 0;
        it     = 0;
        pcnt   = 0;
        while (en_cnt < active_m) begin
            div_load = 1'b0;
            if (it == ld_mid_at) begin
                div_load  = 1'b1;
                div_value = DIV_W'(ld_mid_val);
                shadow_m  = sanitize(ld_mid_val);
            end
            if (abort && en_cnt == active_m - 1) begin
                tif.rst_in = 1'b0;
                tif.ena_in = 1'b1;
                step();
                div_load = 1'b0;
                check_idle("abort");
                return;
            end
            if (en_cnt == pause_at && pcnt < pause_len) begin
                tif.ena_in = 1'b0;
                pcnt++;
            end else begin
                tif.ena_in = 1'b1;
                en_cnt++;
            end
            it++;
            step();
        end
        div_load = 1'b0;
        chk("flag_high", longint'(tif.flag_out), 1);
        chk("flag_busy", longint'(tif.busy), 1);
        for (int h = 1; h <= hold; h++) begin
            tif.rst_in = 1'b1;
            tif.ena_in = 1'($urandom_range(0, 1));
            step();
            chk("hold_flag", longint'(tif.flag_out), 1);
            chk("hold_overrun", longint'(overrun), longint'(ov_m || h >= ACK_TO));
        end
        if (hold >= ACK_TO) ov_m = 1'b1;
        if (rst_in_flag) begin
            reset = 1'b1;
            step();
            reset      = 1'b0;
            tif.rst_in = 1'b0;
            tif.ena_in = 1'b0;
            model_reset();
            check_idle("reset_flag");
            return;
        end
        tif.rst_in = 1'b0;
        tif.ena_in = 1'($urandom_range(0, 1));
        step();
        check_idle("ack");
    endtask

    task automatic reset_mid_count(input int n);
        tif.rst_in = 1'b1;
        tif.ena_in = 1'b1;
        active_m   = shadow_m;
        step();
        repeat (n) step();
        chk("midcount_busy", longint'(tif.busy), 1);
        reset = 1'b1;
        step();
        reset      = 1'b0;
        tif.rst_in = 1'b0;
        tif.ena_in = 1'b0;
        model_reset();
        check_idle("reset_count");
    endtask

    initial begin
        int dv;
        reset      = 1'b1;
        tif.rst_in = 1'b0;
        tif.ena_in = 1'b0;
        div_load   = 1'b0;
        div_value  = '0;
        model_reset();
        fork
            monitor();
        join_none
        step();
        step();
        reset = 1'b0;
        check_idle("reset");
        idle_gap(3);

        // default 250 period, divisor 4 loaded mid-period takes effect next period
        run_period(1'b0, 0, 50, 4, 1000, 0, 1'b0, 0, 1'b0);
        run_period(1'b0, 0, -1, 0, 1000, 0, 1'b0, 0, 1'b0);
        // divisor 10 loaded with the start, five paused cycles
        run_period(1'b1, 10, -1, 0, 3, 5, 1'b0, 0, 1'b0);
        // abort on the terminal-count cycle
        run_period(1'b0, 0, -1, 0, 1000, 0, 1'b1, 0, 1'b0);
        idle_gap(2);
        // acknowledge withheld long enough to set overrun, which then sticks
        run_period(1'b0, 0, -1, 0, 1000, 0, 1'b0, ACK_TO, 1'b0);
        run_period(1'b0, 0, -1, 0, 1000, 0, 1'b0, 2, 1'b0);
        // reset while FLAG, then reset while counting
        run_period(1'b1, 3, -1, 0, 1000, 0, 1'b0, 1, 1'b1);
        reset_mid_count(100);

        // zero divisor means 1; continuous handshake through the tick wrap
        run_period(1'b1, 0, -1, 0, 1000, 0, 1'b0, 0, 1'b0);
        repeat (299) run_period(1'b0, 0, -1, 0, 1000, 0, 1'b0, 0, 1'b0);

        repeat (60) begin
            dv = $urandom_range(0, 12);
            run_period(1'($urandom_range(0, 1)), longint'(dv),
                       ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : -1,
                       longint'($urandom_range(0, 9)),
                       $urandom_range(0, 12), $urandom_range(0, 4),
                       ($urandom_range(0, 7) == 0),
                       ($urandom_range(0, 9) == 0) ? 16 : $urandom_range(0, 3),
                       1'b0);
            if ($urandom_range(0, 3) == 0) idle_gap($urandom_range(1, 3));
        end

        repeat (3) step();
        chk("scoreboard_drained", longint'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/timer_tick_gen.md
Name: timer_tick_gen

Overview:
- Counter-side responder of the timer control handshake.
- The timer controller drives `rst_in` and `ena_in`. This block runs a programmable prescaler and raises `flag_out` after each elapsed divisor period.
- It holds `flag_out` until the controller acknowledges by driving `rst_in` low.
- It sits beside the timer controller in the medicine-reminder timer path and supplies the base tick that the controller accumulates into seconds, minutes and hours.

Parameters:
- DIV_W, 24, width of the divisor and prescale counter.
- DEFAULT_DIV, 250, divisor in effect after reset (clock cycles per tick).
- ACK_TIMEOUT, 15, number of FLAG cycles without acknowledge before `overrun` sets.
- TC_W, 16, width of the tick counter.

Ports:
- clock, input, 1, system clock; all logic on the rising edge.
- reset, input, 1, synchronous, active-high; clears all state.
- rst_in, input, 1, active-low clear/acknowledge from the controller; 1 = run.
- ena_in, input, 1, count enable from the controller.
- div_load, input, 1, one-cycle strobe that captures `div_value` into the shadow register.
- div_value, input, DIV_W, new divisor.
- flag_out, input-to-controller output, 1, tick elapsed; registered; held until acknowledged.
- busy, output, 1, high when state is not IDLE.
- overrun, output, 1, sticky; acknowledge not received within ACK_TIMEOUT.
- tick_count, output, TC_W, number of ticks generated; wraps modulo 2^TC_W.
- div_active, output, DIV_W, divisor currently in use.

Behaviour:
- Reset values (reset=1 at an edge):
  - state=IDLE, cnt=0.
  - div_shadow=DEFAULT_DIV, div_active=DEFAULT_DIV.
  - flag_out=0, busy=0, overrun=0, tick_count=0, watchdog=0.
  - reset overrides every other input.
- Divisor load:
  - `div_load`=1 in any state writes `div_shadow`.
  - `div_value`=0 is stored as 1.
  - `div_active` takes `div_shadow` only on the IDLE->COUNT transition; a running period is never altered.
  - A load and an IDLE->COUNT transition in the same cycle use the new value.
- State IDLE:
  - flag_out=0.
  - `rst_in`=1 and `ena_in`=1 -> COUNT, cnt=0; otherwise stay.
- State COUNT:
  - `rst_in`=0 -> IDLE, cnt=0. This has priority, including over the terminal count.
  - Else `ena_in`=1 and cnt==div_active-1 -> FLAG, cnt=0, tick_count+1.
  - Else `ena_in`=1 -> cnt+1.
  - Else (`ena_in`=0) -> hold cnt and stay (pause).
- Tick timing:
  - `flag_out` rises exactly div_active enabled COUNT cycles after COUNT entry.
  - With div_active=1, FLAG is entered on the first enabled COUNT cycle.
- State FLAG:
  - flag_out=1, cnt held at 0.
  - `rst_in`=0 -> IDLE. `flag_out` is 0 on the following cycle and watchdog clears.
  - `rst_in`=1 -> watchdog+1 (saturating).
  - When watchdog reaches ACK_TIMEOUT, `overrun` sets to 1 and stays 1 until reset; FLAG is retained.
  - `ena_in` is ignored in FLAG.
- Handshake sequence (controller registers its outputs, one cycle of latency each way):
  - flag_out=1 -> controller drives rst_in=0 -> flag_out=0.
  - Controller then sees flag=0 and drives rst_in=1, ena_in=1 -> next period starts.
- Output definitions:
  - busy = (state != IDLE).
  - `div_active`, `tick_count` and `overrun` are direct register outputs.
  - All outputs are registered; nothing combinational from inputs to outputs.
- Illegal state encoding -> IDLE with cnt=0, flag_out=0.

Decomposition:
- Package `timer_pkg`:
  - state enum {IDLE, COUNT, FLAG}.
  - DIV_W/TC_W default constants and DEFAULT_DIV.
  - shared by the timer controller and this block.
- One natural sub-module, `timer_ack_watchdog`: saturating counter with clear, ACK_TIMEOUT compare and sticky `overrun`.
- Prescaler and FSM stay in the top module.

Test Plan:
- Reset then rst_in=1, ena_in=1 held, DEFAULT_DIV=250 -> flag_out rises exactly 250 cycles after COUNT entry; tick_count=1; acknowledge with rst_in=0 for 1 cycle -> flag_out=0 next cycle; busy=0.
- div_load with div_value=4 while counting with div_active=250 -> current period still 250; next period flags after 4 enabled cycles; div_active=4.
- div_value=0 loaded, continuous handshake -> div_active=1; flag every period after 1 enabled cycle; tick_count increments each handshake and wraps from 65535 to 0.
- div=10, ena_in low for cycles 3-7 of the period -> flag delayed by exactly 5 cycles (15 total); rst_in=0 on the cycle cnt==9 -> no flag, state IDLE, tick_count unchanged.
- FLAG with rst_in held 1 for 15 cycles -> overrun=1, flag_out still 1; acknowledge -> flag_out=0, overrun stays 1 until reset.
- reset asserted mid-COUNT (cnt=100) and mid-FLAG -> next cycle all outputs at reset values; div_active=250.
